// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } arb_gnt_t;

    localparam int MEM_AW_DEF = 14;
    localparam int LAT_CW     = $clog2(4) + 1;

endpackage

`default_nettype wire

// File: rtl/mem_arb_lat_cnt.sv
// ============================================================================
// Module      : mem_arb_lat_cnt
// Description : Loadable read-latency down-counter; done flags the last WAIT cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    // Loaded with MEM_LAT-1 so that WAIT lasts MEM_LAT-1 cycles.
    localparam logic [LAT_CW-1:0] C_LOAD = LAT_CW'(MEM_LAT - 1);

    logic [LAT_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_LOAD;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - LAT_CW'(1);
        end
    end

    assign done = (r_count == LAT_CW'(1));

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-ported memory macro between IF and DM requesters.
//               Define MEM_ARB_RR_EN for round-robin arbitration (default: DM over IF).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int MEM_AW  = MEM_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_ready,
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_di,
    input  logic [31:0]       mem_do,
    output logic              stall
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_gnt_t          r_gnt;
    arb_gnt_t          w_gnt_sel;
    logic [MEM_AW-1:0] r_addr;
    logic [3:0]        r_we;
    logic [31:0]       r_wdata;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_dm_rdata;
    logic              w_any_req;
    logic              w_is_read;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_done;
    logic              w_issue;
    logic              w_resp;
    logic              w_grant;
    logic              w_unused;

    assign w_any_req = if_req | dm_req;
    assign w_is_read = (r_we == 4'b0000);
    assign w_grant   = (r_state == IDLE) && w_any_req;

`ifdef MEM_ARB_RR_EN
    arb_gnt_t r_last_gnt;

    // On a tie the requester not served last time wins.
    always_comb begin
        w_gnt_sel = GNT_IF;
        if (dm_req && if_req) begin
            if (r_last_gnt == GNT_DM) begin
                w_gnt_sel = GNT_IF;
            end else begin
                w_gnt_sel = GNT_DM;
            end
        end else if (dm_req) begin
            w_gnt_sel = GNT_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= GNT_IF;
        end else if (w_grant) begin
            r_last_gnt <= w_gnt_sel;
        end
    end
`else
    always_comb begin
        w_gnt_sel = GNT_IF;
        if (dm_req) begin
            w_gnt_sel = GNT_DM;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_is_read && (MEM_LAT > 1)) begin
                    w_state_nxt = WAIT;
                    w_cnt_load  = 1'b1;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            WAIT: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_done) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= GNT_IF;
            r_addr     <= '0;
            r_we       <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_gnt <= w_gnt_sel;
                if (w_gnt_sel == GNT_DM) begin
                    r_addr  <= dm_addr[MEM_AW+1:2];
                    r_we    <= dm_we;
                    r_wdata <= dm_wdata;
                end else begin
                    r_addr  <= if_addr[MEM_AW+1:2];
                    r_we    <= '0;
                    r_wdata <= '0;
                end
            end
            if ((r_state == RESP) && w_is_read) begin
                if (r_gnt == GNT_DM) begin
                    r_dm_rdata <= mem_do;
                end else begin
                    r_if_rdata <= mem_do;
                end
            end
        end
    end

    mem_arb_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (w_cnt_load),
        .dec  (w_cnt_dec),
        .done (w_cnt_done)
    );

    assign w_issue  = (r_state == ISSUE);
    assign w_resp   = (r_state == RESP);

    assign mem_cs   = w_issue;
    assign mem_we   = w_issue ? r_we    : 4'b0000;
    assign mem_addr = w_issue ? r_addr  : '0;
    assign mem_di   = w_issue ? r_wdata : 32'h0;

    assign if_ready = w_resp && (r_gnt == GNT_IF);
    assign dm_ready = w_resp && (r_gnt == GNT_DM);

    // Read data is passed through during RESP so it is valid alongside ready.
    assign if_rdata = if_ready ? mem_do : r_if_rdata;
    assign dm_rdata = (dm_ready && w_is_read) ? mem_do : r_dm_rdata;

    assign stall    = (if_req & ~if_ready) | (dm_req & ~dm_ready);

    assign w_unused = ^{if_addr[1:0], if_addr[31:MEM_AW+2], dm_addr[1:0], dm_addr[31:MEM_AW+2]};

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-ported memory macro between the instruction-fetch (IF) requester and the data-memory (MEM-stage load/store) requester. It grants one requester at a time, sequences the macro's chip-select, write enables and fixed read latency, and returns read data with a one-cycle ready pulse. It also drives the pipeline-wide stall while any request is outstanding. It sits between the IF/MEM stages and the memory wrapper, downstream of the control unit's mem_r/mem_w decode.

## Interface
- MEM_LAT, 1: memory read latency in cycles, from the cycle cs is asserted to the cycle data is valid; legal range 1..4
- MEM_AW, 14: memory word-address width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  instruction fetch request; held until if_ready
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched instruction; valid when if_ready
- if_ready  out  1  one-cycle completion pulse
- dm_req  in  1  data request (mem_r | mem_w); held until dm_ready
- dm_we  in  4  byte write enables; 0 means read
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data; valid when dm_ready
- dm_ready  out  1  one-cycle completion pulse
- mem_cs  out  1  macro chip select
- mem_we  out  4  macro byte write enables, active-high
- mem_addr  out  MEM_AW  word address, taken from addr[MEM_AW+1:2]
- mem_di  out  32  macro write data
- mem_do  in  32  macro read data
- stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational

## Operation
- FSM states and transitions:
  - IDLE: if any request is pending, go to ISSUE and latch the grant, address, we and wdata.
  - ISSUE: go to WAIT if this is a read and MEM_LAT > 1; otherwise go to RESP.
  - WAIT: decrement the latency counter; go to RESP when it reaches 1.
  - RESP: return to IDLE.
- Grant priority (default): DM over IF, because the MEM-stage instruction is older. If both requests appear in the same IDLE cycle, DM is served first and IF in the next transaction.
- ISSUE: mem_cs=1 and mem_addr/mem_we/mem_di are driven from the latched values for exactly one cycle. They are 0 in every other state.
- Reads: in RESP, mem_do is captured into the granted requester's rdata register, and the matching ready is pulsed.
- Writes: RESP pulses dm_ready. rdata is unchanged and the latency counter is skipped.
- Inputs are sampled only in IDLE. A request dropped early is protocol misuse; the transaction still completes.
- addr[1:0] is ignored; the arbiter does no alignment checking.
- rdata registers hold their value until the next read for that requester.
- Reset, including mid-transaction: go to IDLE, clear all outputs to 0 (ready, mem_cs, mem_we, mem_addr, mem_di, rdata), clear the counter and the RR pointer, and discard any in-flight access.

## Timing
- A request seen in IDLE at edge k gives mem_cs high during cycle k+1.
- Read ready: high during cycle k+MEM_LAT+1, with rdata valid in the same cycle.
- Write ready: high during cycle k+2.
- Next grant is earliest at the edge after RESP. Back-to-back throughput is one read per MEM_LAT+2 cycles and one write per 3 cycles.
- stall falls in the same cycle ready rises, so the pipeline advances on that edge.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. A one-bit pointer records the last grant. On simultaneous requests the other requester wins, and the pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed DM-over-IF priority and no pointer flop.

## Structure
- Package mem_arb_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP
  - grant enum: GNT_IF, GNT_DM
  - MEM_AW_DEF=14
  - LAT_CW = $clog2(4)+1
- Sub-module mem_arb_lat_cnt: loadable down-counter taking MEM_LAT, with a done flag. Everything else is inline.

## Test plan
- Reset mid-read (MEM_LAT=3, rst in cycle 2 of WAIT): next cycle all outputs are 0 and state is IDLE; no ready pulse follows.
- Single IF read, addr 0x0000_0010, mem_do=0x0051_3093, MEM_LAT=1: mem_addr=4 and cs=1 at k+1; if_ready=1 and if_rdata=0x0051_3093 at k+2; stall high during k..k+1.
- DM byte store, we=4'b0010, addr 0x0000_0105, wdata 0xAABB_CCDD: mem_addr=0x41, mem_we=4'b0010, mem_di=0xAABB_CCDD for one cycle; dm_ready at k+2.
- Simultaneous if_req and dm_req (load), MEM_LAT=2: DM is served first with dm_ready at k+3; the IF grant follows with if_ready at k+7; no overlap of cs.
- With MEM_ARB_RR_EN, three rounds of continuous simultaneous requests: grants alternate DM, IF, DM; without the macro, DM starves IF while dm_req stays high.
- MEM_LAT=4 read: exactly three WAIT cycles, ready at k+5, and mem_do is sampled only in RESP (changing mem_do earlier does not affect rdata).
